spi_master_ctrl: RTL and testbench

SPI controller (initiator) for the stepper driver's 40-bit register protocol: 8-bit address byte, then 32 data bits, MSB first, mode 0. It lets a host-side controller, or a second tile on the test board, write and read the driver's four 32-bit registers (step position, reg1-3). The user side is a start/busy/done handshake. The pin side drives sclk, cs_n and mosi and samples miso.

---
 rtl/spi_pkg.sv | 40 ++++
 rtl/spi_clk_divider.sv | 46 ++++
 rtl/spi_master_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the stepper-driver SPI initiator.
// Holds the frame geometry (8-bit address byte + 32 data bits), the
// register index constants of the driver and the controller state type.
// A helper assembles the 40-bit frame shifted out MSB first.

package spi_pkg;

    localparam int SPI_ADDR_W     = 8;
    localparam int SPI_DATA_W     = 32;
    localparam int SPI_FRAME_BITS = 40;
    localparam int SPI_WRITE_BIT  = 7;

    // Register indices of the stepper driver
    localparam logic [6:0] REG_STEP_POS = 7'd0;
    localparam logic [6:0] REG_1        = 7'd1;
    localparam logic [6:0] REG_2        = 7'd2;
    localparam logic [6:0] REG_3        = 7'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    // Address byte carries the write flag in its top bit; a read sends
    // zeros during the data phase.
    function automatic logic [SPI_FRAME_BITS-1:0] spi_build_frame(
        input logic                  rw_write,
        input logic [6:0]            reg_addr,
        input logic [SPI_DATA_W-1:0] wr_data
    );
        logic [SPI_ADDR_W-1:0] addr_byte;
        addr_byte                = {1'b0, reg_addr};
        addr_byte[SPI_WRITE_BIT] = rw_write;
        return {addr_byte, (rw_write ? wr_data : {SPI_DATA_W{1'b0}})};
    endfunction

endpackage

// File: rtl/spi_clk_divider.sv
// Half-bit tick generator for the SPI initiator.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   en_i        - counting enable; while low the counter is held at 0
//   tick_o      - high for one clk cycle at the end of every half-bit
// The 8-bit counter runs 0..H-1 and wraps to 0, so a tick fires every H
// cycles counted from the cycle after enable rises.

module spi_clk_divider #(
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_HALF_BIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Holding the counter at zero while idle aligns the first half-bit
    // exactly with the cycle in which chip select drops.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = 8'd0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator for the stepper driver's 40-bit register protocol.
// Ports:
//   clk, rst_n          - system clock, asynchronous active-low reset
//   start               - request a frame; only looked at while idle
//   rw_write, reg_addr  - form the address byte {rw_write, reg_addr}
//   wr_data             - write payload (zeros are sent for reads)
//   busy                - frame in progress, including the cs_n gap
//   done                - one-cycle pulse as cs_n returns high
//   rd_data             - last 32 bits sampled from spi_miso
//   spi_clk, spi_cs_n, spi_mosi, spi_miso - SPI pins

module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_GAP_HALF_BITS  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rw_write,
    input  logic [6:0]  reg_addr,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        spi_clk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    // Half-bit index of the last SCLK-high phase; the falling edge that
    // ends it is the 40th and final one.
    localparam logic [6:0] LAST_EDGE = 7'(2 * SPI_FRAME_BITS - 2);
    localparam logic [6:0] GAP_LAST  = 7'(CS_GAP_HALF_BITS - 1);

    spi_state_e                state_q, state_d;
    logic [SPI_FRAME_BITS-1:0] tx_q, tx_d;
    logic [SPI_DATA_W-1:0]     rx_q, rx_d;
    logic [SPI_DATA_W-1:0]     rd_q, rd_d;
    logic [6:0]                edge_q, edge_d;
    logic                      sclk_q, sclk_d;
    logic                      cs_n_q, cs_n_d;
    logic                      mosi_q, mosi_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      tick;
    logic [SPI_FRAME_BITS-1:0] frame;

    spi_clk_divider #(
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q != ST_IDLE),
        .tick_o(tick)
    );

    assign frame = spi_build_frame(rw_write, reg_addr, wr_data);

    // Next-state and datapath logic. Every pin is a register output, so
    // all pin changes are decided here one cycle ahead. MISO is sampled
    // on the clk edge that raises SCLK; the capture register is only 32
    // bits wide so the address-phase bits fall off its top end.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        edge_d  = edge_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    mosi_d  = frame[SPI_FRAME_BITS-1];
                    tx_d    = {frame[SPI_FRAME_BITS-2:0], 1'b0};
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    edge_d  = 7'd0;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[SPI_DATA_W-2:0], spi_miso};
                    edge_d  = 7'd0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (edge_q == LAST_EDGE) begin
                        state_d = ST_HOLD;
                        edge_d  = 7'd0;
                    end else begin
                        edge_d = edge_q + 7'd1;
                        if (sclk_q) begin
                            mosi_d = tx_q[SPI_FRAME_BITS-1];
                            tx_d   = {tx_q[SPI_FRAME_BITS-2:0], 1'b0};
                        end else begin
                            rx_d = {rx_q[SPI_DATA_W-2:0], spi_miso};
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_GAP;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    rd_d    = rx_q;
                    edge_d  = 7'd0;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (edge_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        edge_d  = 7'd0;
                    end else begin
                        edge_d = edge_q + 7'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset returns the pins to their idle levels immediately, which
    // also aborts any frame in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rd_q    <= '0;
            edge_q  <= 7'd0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            edge_q  <= edge_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_q;
    assign spi_clk  = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl.
// Instance dut2 (H=2) talks to a register-file slave model and is checked
// every cycle against a timing model computed from the frame timeline.
// Instance dut1 (H=1) runs back-to-back frames with MISO looped to MOSI.

module tb_spi_master_ctrl;

    localparam int H        = 2;
    localparam int G        = 2;
    localparam int CS_RISE  = 1 + 81 * H;
    localparam int END_T    = 1 + (81 + G) * H;

    int checks   = 0;
    int failures = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rwWrite = 1'b0;
    logic [6:0]  regAddr = 7'd0;
    logic [31:0] wrData = 32'd0;
    logic        busy, done, sclk, csN, mosi;
    logic [31:0] rdData;
    logic        miso = 1'b0;

    logic        rst1N = 1'b0;
    logic        start1 = 1'b0;
    logic        rw1 = 1'b1;
    logic [6:0]  addr1 = 7'd3;
    logic [31:0] wrData1 = 32'hA5C30F96;
    logic        busy1, done1, sclk1, csN1, mosi1;
    logic [31:0] rdData1;

    always #5 clk = ~clk;

    spi_master_ctrl #(.CLKS_PER_HALF_BIT(H), .CS_GAP_HALF_BITS(G)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .rw_write(rwWrite),
        .reg_addr(regAddr), .wr_data(wrData), .busy(busy), .done(done),
        .rd_data(rdData), .spi_clk(sclk), .spi_cs_n(csN), .spi_mosi(mosi),
        .spi_miso(miso)
    );

    spi_master_ctrl #(.CLKS_PER_HALF_BIT(1), .CS_GAP_HALF_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst1N), .start(start1), .rw_write(rw1),
        .reg_addr(addr1), .wr_data(wrData1), .busy(busy1), .done(done1),
        .rd_data(rdData1), .spi_clk(sclk1), .spi_cs_n(csN1), .spi_mosi(mosi1),
        .spi_miso(mosi1)
    );

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Slave register file: the driver's four registers
    logic [31:0] sRegs [0:3] = '{32'h0, 32'h0, 32'h0034BF15, 32'h0};
    logic        sPrevCs = 1'b1;
    logic        sPrevSclk = 1'b0;
    int          sBits = 0;
    int          sFrames = 0;
    int          sLastBits = 0;
    logic [39:0] sShift = '0;
    logic [39:0] sLastFrame = '0;
    logic [7:0]  sAddr = '0;

    // Slave model, oversampling the pins mid-cycle: shifts MOSI in on SCLK
    // rise, drives MISO on SCLK fall, zeros during the address byte, and
    // commits a write only when a full 40-bit frame arrived.
    always @(negedge clk) begin
        sPrevCs   <= csN;
        sPrevSclk <= sclk;
        if (sPrevCs && !csN) begin
            sBits  <= 0;
            sShift <= '0;
            miso   <= 1'b0;
        end else if (!sPrevCs && csN) begin
            sLastFrame <= sShift;
            sLastBits  <= sBits;
            sFrames    <= sFrames + 1;
            miso       <= 1'b0;
            if (sAddr[7] && sBits == 40) sRegs[sAddr[1:0]] <= sShift[31:0];
        end else if (!csN && !sPrevSclk && sclk) begin
            sShift <= {sShift[38:0], mosi};
            sBits  <= sBits + 1;
            if (sBits == 7) sAddr <= {sShift[6:0], mosi};
        end else if (!csN && sPrevSclk && !sclk) begin
            if (sBits >= 8 && sBits < 40) miso <= sRegs[sAddr[1:0]][39 - sBits];
        end
    end

    // Timeline model: mT is the cycle index within the current frame,
    // cycle 1 being the one after start is accepted.
    logic        mActive;
    int          mT;
    logic [39:0] mFrame;
    logic [31:0] mRd, mRdNext;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mActive <= 1'b0;
            mT      <= 0;
            mFrame  <= '0;
            mRd     <= '0;
            mRdNext <= '0;
        end else if (!mActive && start) begin
            mActive <= 1'b1;
            mT      <= 1;
            mFrame  <= {rwWrite, regAddr, (rwWrite ? wrData : 32'h0)};
            mRdNext <= sRegs[regAddr[1:0]];
        end else if (mActive) begin
            mT <= mT + 1;
            if (mT + 1 == END_T) mActive <= 1'b0;
            if (mT + 1 == CS_RISE) mRd <= mRdNext;
        end
    end

    // Per-cycle comparison of dut2 pins and handshake against the model
    always @(negedge clk) begin : cmp
        logic eb, ec, es, em, ed;
        int   u, adv, idx;
        if (rst_n) begin
            eb  = mActive;
            ec  = !(mActive && mT < CS_RISE);
            ed  = mActive && (mT == CS_RISE);
            u   = mT - 1 - H;
            es  = mActive && (u >= 0) && (u < 80 * H) && (((u / H) % 2) == 0);
            em  = 1'b0;
            if (mActive && mT < CS_RISE) begin
                if (mT < 1 + 2 * H) begin
                    idx = 39;
                end else begin
                    adv = (mT - 1 - 2 * H) / (2 * H) + 1;
                    if (adv > 39) adv = 39;
                    idx = 39 - adv;
                end
                em = mFrame[idx];
            end
            checkVal("pins{busy,cs_n,sclk,mosi,done}", 64'({busy, csN, sclk, mosi, done}),
                     64'({eb, ec, es, em, ed}));
            checkVal("rd_data", 64'(rdData), 64'(mRd));
        end
    end

    // Event times within a frame and pulse counters for dut2
    logic prevCs2 = 1'b1;
    logic prevBusy2 = 1'b0;
    int   csFallT = 0, csRiseT = 0, doneT = 0, busyFallT = 0, doneCnt = 0;

    always @(negedge clk) begin
        prevCs2   <= csN;
        prevBusy2 <= busy;
        if (prevCs2 && !csN) csFallT <= mT;
        if (!prevCs2 && csN) csRiseT <= mT;
        if (prevBusy2 && !busy) busyFallT <= mT;
        if (done) begin
            doneT   <= mT;
            doneCnt <= doneCnt + 1;
        end
    end

    // Back-to-back frame checks for dut1 (H=1, gap of 2 half-bits)
    logic p1Cs = 1'b1;
    logic p1Sclk = 1'b0;
    logic seen1 = 1'b0;
    int   cyc1 = 0, lastFall1 = 0, lowRun = 0, highRun = 0, rises1 = 0, frames1 = 0;

    always @(negedge clk) begin
        if (rst1N) begin
            p1Cs   <= csN1;
            p1Sclk <= sclk1;
            cyc1   <= cyc1 + 1;
            if (p1Cs && !csN1) begin
                if (seen1) begin
                    checkVal("h1_cs_high_cycles", 64'(highRun), 64'd3);
                    checkVal("h1_frame_period", 64'(cyc1 - lastFall1), 64'd84);
                end
                seen1     <= 1'b1;
                lastFall1 <= cyc1;
                lowRun    <= 1;
                rises1    <= 0;
            end else if (!csN1) begin
                lowRun <= lowRun + 1;
            end
            if (!p1Cs && csN1) begin
                checkVal("h1_cs_low_cycles", 64'(lowRun), 64'd81);
                checkVal("h1_sclk_rises", 64'(rises1), 64'd40);
                frames1 <= frames1 + 1;
                highRun <= 1;
            end else if (csN1) begin
                highRun <= highRun + 1;
            end
            if (!csN1 && !p1Sclk && sclk1) rises1 <= rises1 + 1;
        end
    end

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((mActive || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout busy=%0b required=0", tag, busy);
        end
        @(negedge clk);
    endtask

    task automatic waitFrameCycle(input int target);
        int n;
        n = 0;
        while (mT < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_cycle_%0d_timeout mT=%0d", target, mT);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [31:0] data);
        @(negedge clk);
        rwWrite = rw;
        regAddr = addr;
        wrData  = data;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [39:0] expFrame);
        checkVal({tag, "_mosi_frame"}, 64'(sLastFrame), 64'(expFrame));
        checkVal({tag, "_frame_bits"}, 64'(sLastBits), 64'd40);
    endtask

    initial begin : stim
        int f0, d0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_pins{cs_n,sclk,mosi,busy,done}", 64'({csN, sclk, mosi, busy, done}), 64'b10000);
        checkVal("reset_rd_data", 64'(rdData), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rst1N = 1'b1;
        @(negedge clk);
        start1 = 1'b1;

        // Write reg0 = 3: fixed cycle numbers of the frame timeline
        applyStimulus(1'b1, 7'd0, 32'h00000003);
        waitIdle("write0");
        checkOutput("write0", 40'h8000000003);
        checkVal("write0_cs_fall_cycle", 64'(csFallT), 64'd1);
        checkVal("write0_cs_rise_cycle", 64'(csRiseT), 64'd163);
        checkVal("write0_done_cycle", 64'(doneT), 64'd163);
        checkVal("write0_busy_fall_cycle", 64'(busyFallT), 64'd167);

        // Read reg2 returns the slave's preset value
        applyStimulus(1'b0, 7'd2, 32'hFFFFFFFF);
        waitIdle("read2");
        checkOutput("read2", 40'h0200000000);
        checkVal("read2_rd_data", 64'(rdData), 64'h0034BF15);

        // Write then read back reg1 through the slave register file
        applyStimulus(1'b1, 7'd1, 32'h12345678);
        waitIdle("write1");
        checkOutput("write1", 40'h8112345678);
        checkVal("slave_reg1", 64'(sRegs[1]), 64'h12345678);
        applyStimulus(1'b0, 7'd1, 32'h0);
        waitIdle("read1");
        checkOutput("read1", 40'h0100000000);
        checkVal("read1_rd_data", 64'(rdData), 64'h12345678);

        // start pulses during a frame are ignored
        f0 = sFrames;
        d0 = doneCnt;
        applyStimulus(1'b1, 7'd3, 32'hCAFEF00D);
        waitFrameCycle(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitFrameCycle(50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle("ignore");
        repeat (4) @(negedge clk);
        checkVal("ignore_frame_count", 64'(sFrames - f0), 64'd1);
        checkVal("ignore_done_count", 64'(doneCnt - d0), 64'd1);
        checkVal("slave_reg3", 64'(sRegs[3]), 64'hCAFEF00D);

        // Asynchronous reset mid-frame, then a clean frame afterwards
        d0 = doneCnt;
        applyStimulus(1'b0, 7'd3, 32'h0);
        waitFrameCycle(60);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async_reset{cs_n,sclk,busy}", 64'({csN, sclk, busy}), 64'b100);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        checkVal("async_reset_no_done", 64'(doneCnt - d0), 64'd0);
        applyStimulus(1'b1, 7'd2, 32'h0BADBEEF);
        waitIdle("after_reset");
        checkOutput("after_reset", 40'h820BADBEEF);
        checkVal("after_reset_rd_echo", 64'(rdData), 64'h0034BF15);
        checkVal("slave_reg2", 64'(sRegs[2]), 64'h0BADBEEF);

        // Let dut1 finish its back-to-back run
        start1 = 1'b0;
        begin : drain1
            int n;
            n = 0;
            while (busy1 && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) begin
                checks++;
                failures++;
                $display("[TB] FAIL h1_drain_timeout busy=%0b required=0", busy1);
            end
        end
        @(negedge clk);
        checkVal("h1_frames_at_least_3", 64'(frames1 >= 3), 64'd1);
        checkVal("h1_loopback_rd_data", 64'(rdData1), 64'hA5C30F96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
